// File: rtl/clock_delay_tap_cal.sv
// clock_delay_tap_cal: sweeps the clock-delay taps, scores each against the pattern checker, and locks to the centre of the longest passing window
module clock_delay_tap_cal #(
    parameter int NUM_TAPS   = 8,
    parameter int TAP_W      = 3,
    parameter int SETTLE_CYC = 16,
    parameter int SAMPLE_CYC = 256,
    parameter int ERR_TH     = 0,
    parameter int DEF_TAP    = 0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iMATCH_V,
    input  logic             iMATCH,
    output logic [TAP_W-1:0] oTAP,
    output logic             oBUSY,
    output logic             oLOCKED,
    output logic             oFAIL,
    output logic [TAP_W-1:0] oWIN_LO,
    output logic [TAP_W-1:0] oWIN_HI
);
    localparam int CNT_MAX = SETTLE_CYC > SAMPLE_CYC ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam int EW = $clog2(SAMPLE_CYC + 1);
    localparam logic [TAP_W-1:0] LAST = TAP_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EVAL, CENTER, LOCK, FAIL} state_t;

    state_t           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d, run_lo_q, run_lo_d, best_lo_q, best_lo_d, best_hi_q, best_hi_d;
    logic [TAP_W-1:0] win_lo_q, win_lo_d, win_hi_q, win_hi_d, cand_lo, cand_hi;
    logic [TAP_W:0]   best_len_q, best_len_d, cand_len, mid;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EW-1:0]    err_q, err_d;
    logic             run_act_q, run_act_d, pass, last;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            tap_q      <= TAP_W'(DEF_TAP);
            cnt_q      <= '0;
            err_q      <= '0;
            run_act_q  <= 1'b0;
            run_lo_q   <= '0;
            best_lo_q  <= '0;
            best_hi_q  <= '0;
            best_len_q <= '0;
            win_lo_q   <= '0;
            win_hi_q   <= '0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            run_act_q  <= run_act_d;
            run_lo_q   <= run_lo_d;
            best_lo_q  <= best_lo_d;
            best_hi_q  <= best_hi_d;
            best_len_q <= best_len_d;
            win_lo_q   <= win_lo_d;
            win_hi_q   <= win_hi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        run_act_d  = run_act_q;
        run_lo_d   = run_lo_q;
        best_lo_d  = best_lo_q;
        best_hi_d  = best_hi_q;
        best_len_d = best_len_q;
        win_lo_d   = win_lo_q;
        win_hi_d   = win_hi_q;
        pass       = int'(err_q) <= ERR_TH;
        last       = tap_q == LAST;
        cand_lo    = run_act_q ? run_lo_q : tap_q;
        cand_hi    = pass ? tap_q : tap_q - 1'b1;
        cand_len   = {1'b0, cand_hi} - {1'b0, cand_lo} + 1'b1;
        mid        = {1'b0, best_lo_q} + {1'b0, best_hi_q};
        case (state_q)
            IDLE, LOCK, FAIL: begin
                if (iSTART) begin
                    state_d    = SETTLE;
                    tap_d      = '0;
                    cnt_d      = '0;
                    err_d      = '0;
                    run_act_d  = 1'b0;
                    run_lo_d   = '0;
                    best_lo_d  = '0;
                    best_hi_d  = '0;
                    best_len_d = '0;
                end
            end
            SETTLE: begin
                cnt_d   = cnt_q == CW'(SETTLE_CYC - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(SETTLE_CYC - 1) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                cnt_d   = cnt_q == CW'(SAMPLE_CYC - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(SAMPLE_CYC - 1) ? EVAL : SAMPLE;
                err_d   = (iMATCH_V && !iMATCH && err_q != '1) ? err_q + 1'b1 : err_q;
            end
            EVAL: begin
                run_act_d = pass;
                run_lo_d  = cand_lo;
                // a run is scored when it closes: on a failing tap, or on the last tap while still passing
                if ((pass ? last : run_act_q) && cand_len > best_len_q) begin
                    best_lo_d  = cand_lo;
                    best_hi_d  = cand_hi;
                    best_len_d = cand_len;
                end
                state_d = last ? CENTER : SETTLE;
                tap_d   = last ? tap_q : tap_q + 1'b1;
                err_d   = last ? err_q : '0;
            end
            CENTER: begin
                state_d  = best_len_q == '0 ? FAIL : LOCK;
                tap_d    = best_len_q == '0 ? TAP_W'(DEF_TAP) : TAP_W'(mid >> 1);
                win_lo_d = best_len_q == '0 ? win_lo_q : best_lo_q;
                win_hi_d = best_len_q == '0 ? win_hi_q : best_hi_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign oTAP    = tap_q;
    assign oBUSY   = state_q == SETTLE || state_q == SAMPLE || state_q == EVAL || state_q == CENTER;
    assign oLOCKED = state_q == LOCK;
    assign oFAIL   = state_q == FAIL;
    assign oWIN_LO = win_lo_q;
    assign oWIN_HI = win_hi_q;
endmodule

// File: tb/tb_clock_delay_tap_cal.sv
// tb_clock_delay_tap_cal: table-driven calibration runs on two threshold variants with a queued expectation scoreboard
module tb_clock_delay_tap_cal;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, mv, m;
    logic [2:0] tap0, lo0, hi0, tap2, lo2, hi2;
    logic       busy0, lk0, fl0, busy2, lk2, fl2;

    clock_delay_tap_cal dut0 (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iMATCH_V(mv), .iMATCH(m),
        .oTAP(tap0), .oBUSY(busy0), .oLOCKED(lk0), .oFAIL(fl0), .oWIN_LO(lo0), .oWIN_HI(hi0)
    );
    clock_delay_tap_cal #(.ERR_TH(2)) dut2 (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iMATCH_V(mv), .iMATCH(m),
        .oTAP(tap2), .oBUSY(busy2), .oLOCKED(lk2), .oFAIL(fl2), .oWIN_LO(lo2), .oWIN_HI(hi2)
    );

    typedef struct {
        int lk;
        int fl;
        int tap;
        int lo;
        int hi;
    } exp_t;

    // errs: nibble t is the error count injected on tap t; nov: taps whose sample window has no valid results
    typedef struct {
        bit [31:0] errs;
        bit [7:0]  nov;
        int        smid;
        exp_t      e0;
        exp_t      e2;
    } vec_t;

    vec_t vecs[7];
    exp_t q0[$], q2[$];
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic cmp(input string tag, input exp_t e, input int lk, input int fl, input int tap, input int lo, input int hi);
        chk({tag, "_locked"}, lk, e.lk);
        chk({tag, "_fail"}, fl, e.fl);
        chk({tag, "_tap"}, tap, e.tap);
        if (e.lk != 0) begin
            chk({tag, "_win_lo"}, lo, e.lo);
            chk({tag, "_win_hi"}, hi, e.hi);
        end
    endtask

    // settle and eval cycles carry mismatches that must be ignored; errors land mid-sample
    task automatic drive(input int r, input int k);
        int t, p;
        t = k / 273;
        p = k % 273;
        start = (vecs[r].smid != 0) && (k == 500);
        if (p < 16 || p == 272) begin
            mv = 1'b1;
            m  = 1'b0;
        end else if (vecs[r].nov[t]) begin
            mv = 1'b0;
            m  = 1'b0;
        end else if (p >= 100 && p < 100 + int'(vecs[r].errs[4*t +: 4])) begin
            mv = 1'b1;
            m  = 1'b0;
        end else begin
            mv = $urandom_range(1, 0) != 0;
            m  = mv;
        end
    endtask

    task automatic run_cal(input int r);
        int   lat, tap_bad;
        exp_t e0, e2;
        q0.push_back(vecs[r].e0);
        q2.push_back(vecs[r].e2);
        @(negedge clk);
        start   = 1'b1;
        lat     = 0;
        tap_bad = 0;
        @(posedge clk);
        lat++;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2184; k++) begin
            drive(r, k);
            if (int'(tap0) != k / 273 || int'(tap2) != k / 273 || !busy0 || !busy2) tap_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        mv    = 1'b0;
        m     = 1'b0;
        while (!(lk0 || fl0) && lat < 2300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk($sformatf("row%0d_latency", r), lat, 2186);
        chk($sformatf("row%0d_tap_hold", r), tap_bad, 0);
        chk($sformatf("row%0d_busy_done", r), int'(busy0) + int'(busy2), 0);
        e0 = q0.pop_front();
        e2 = q2.pop_front();
        cmp($sformatf("row%0d_th0", r), e0, lk0, fl0, tap0, lo0, hi0);
        cmp($sformatf("row%0d_th2", r), e2, lk2, fl2, tap2, lo2, hi2);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tap"}, int'(tap0) + int'(tap2), 0);
        chk({tag, "_busy"}, int'(busy0) + int'(busy2), 0);
        chk({tag, "_locked"}, int'(lk0) + int'(lk2), 0);
        chk({tag, "_fail"}, int'(fl0) + int'(fl2), 0);
        chk({tag, "_win"}, int'(lo0) + int'(hi0) + int'(lo2) + int'(hi2), 0);
    endtask

    initial begin
        vecs[0] = '{errs: 32'h1100_0011, nov: 8'h00, smid: 0, e0: '{1, 0, 3, 2, 5}, e2: '{1, 0, 3, 0, 7}};
        vecs[1] = '{errs: 32'h3300_3300, nov: 8'h00, smid: 0, e0: '{1, 0, 0, 0, 1}, e2: '{1, 0, 0, 0, 1}};
        vecs[2] = '{errs: 32'h0003_1300, nov: 8'h00, smid: 0, e0: '{1, 0, 6, 5, 7}, e2: '{1, 0, 6, 5, 7}};
        vecs[3] = '{errs: 32'h5555_5555, nov: 8'h00, smid: 0, e0: '{0, 1, 0, 0, 0}, e2: '{0, 1, 0, 0, 0}};
        vecs[4] = '{errs: 32'h0000_0000, nov: 8'h00, smid: 1, e0: '{1, 0, 3, 0, 7}, e2: '{1, 0, 3, 0, 7}};
        vecs[5] = '{errs: 32'h3032_3333, nov: 8'h40, smid: 0, e0: '{1, 0, 6, 6, 6}, e2: '{1, 0, 4, 4, 4}};
        vecs[6] = '{errs: 32'h0999_9999, nov: 8'h00, smid: 0, e0: '{1, 0, 7, 7, 7}, e2: '{1, 0, 7, 7, 7}};

        rst   = 1'b1;
        start = 1'b0;
        mv    = 1'b0;
        m     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mv    = ~mv;
            m     = ~m;
            start = (i == 2);
        end
        @(negedge clk);
        chk_reset("reset");
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_with_reset_ignored", int'(busy0) + int'(busy2), 0);

        for (int r = 0; r < 7; r++) run_cal(r);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3 * 273 + 100; k++) begin
            drive(0, k);
            @(posedge clk);
            @(negedge clk);
        end
        chk("midrun_tap", int'(tap0), 3);
        chk("midrun_busy", int'(busy0), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midrun_reset");
        repeat (20) @(negedge clk);
        chk("post_reset_idle", int'(busy0) + int'(busy2), 0);
        run_cal(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
